mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS-lite core. It sequences the shared fetch unit, register file, ALU and data memory over 3-5 cycles per instruction, and produces all write strobes and mux selects from a Moore FSM. It consumes the opcode and funct fields held in the IR and the ALU zero flag. It waits on ready handshakes from the instruction and data memories.

Parameters:
CNT_W, 32, width of retired-instruction counter
RST_STATE, 4'd0, encoding loaded into the state register on reset (S_FETCH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], stable from S_DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU equality flag
im_rdy  in  1  instruction memory data valid (tie 1 for single-cycle IM)
dm_rdy  in  1  data memory access complete (tie 1 for single-cycle DM)
pc_wr  out  1  PC register load enable
ir_wr  out  1  IR load enable
npc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs_data
reg_wr  out  1  register-file write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  00 ALU out, 01 MDR, 10 PC (holds PC+4 after fetch)
alu_src  out  1  0 rt data, 1 extended immediate
alu_op  out  3  000 add, 001 sub, 010 or, 011 pass-B (lui)
ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
mem_wr  out  1  data memory write strobe
illegal  out  1  one-cycle pulse on unsupported instruction
state_o  out  4  current state, for debug and bench
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async): state = S_FETCH, instr_cnt = 0. All strobes (pc_wr, ir_wr, reg_wr, mem_wr, illegal) are 0 while reset is high; they are gated combinationally by ~reset. Selects are 0.
- Supported set: addu (R, funct 100001), subu (R, 100011), jr (R, 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States and transitions:
  - S_FETCH: ir_wr = pc_wr = im_rdy, npc_sel = 00. Stay while !im_rdy. Go to S_DECODE when im_rdy.
  - S_DECODE: no strobes. R-alu -> S_EXE_R; ori/lui -> S_EXE_I; lw/sw -> S_MEM_ADR; beq -> S_BRANCH; j/jal/jr -> S_JUMP. Anything else: illegal = 1, -> S_FETCH.
  - S_EXE_R: alu_src = 0; alu_op = 000 (addu) or 001 (subu). -> S_WB_ALU.
  - S_EXE_I: alu_src = 1. For ori: ext_op = 00, alu_op = 010. For lui: ext_op = 10, alu_op = 011. -> S_WB_ALU.
  - S_WB_ALU: reg_wr = 1, wd_sel = 00. reg_dst = 01 for R-type, 00 for I-type. -> S_FETCH.
  - S_MEM_ADR: alu_src = 1, ext_op = 01, alu_op = 000. lw -> S_MEM_RD; sw -> S_MEM_WR.
  - S_MEM_RD: hold address controls. Stay while !dm_rdy; -> S_WB_MEM on dm_rdy. The MDR is loaded by the datapath every cycle.
  - S_MEM_WR: mem_wr = 1 and address controls held until dm_rdy. -> S_FETCH on dm_rdy.
  - S_WB_MEM: reg_wr = 1, reg_dst = 00, wd_sel = 01. -> S_FETCH.
  - S_BRANCH: alu_src = 0, alu_op = 001, npc_sel = 01, pc_wr = zero. -> S_FETCH.
  - S_JUMP: pc_wr = 1. For j/jal, npc_sel = 10; for jr, npc_sel = 11. jal additionally sets reg_wr = 1, reg_dst = 10, wd_sel = 10. -> S_FETCH.
- Latency in cycles (with ready signals high): R/ori/lui 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Branch target is computed by the datapath relative to the PC register, which already holds PC+4 after S_FETCH.
- instr_cnt increments by 1 on each transition into S_FETCH from any completing state. It is not incremented from S_DECODE on an illegal instruction. It wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts immediately: no partial register or memory write occurs after the asserting edge.
- Unused state encodings recover to S_FETCH on the next clock.

Decomposition:
- Shared package mips_defs: opcode and funct constants, state encodings, and the alu_op, ext_op, npc_sel, reg_dst and wd_sel codes.
- One sub-module is natural: mc_ctrl_dec, a combinational state+opcode -> control-word decoder.
- The FSM register, next-state logic and counter stay in mc_ctrl.

Test Plan:
- Reset held 3 cycles, then released, with im_rdy = 1 -> state_o = S_FETCH, all strobes 0 during reset, instr_cnt = 0, then ir_wr = pc_wr = 1 in the first cycle after release.
- addu (opcode 0, funct 100001) followed by lw (100011), ready signals high -> 4 then 5 cycles. reg_wr asserts in cycle 4 with reg_dst = 01, and in cycle 5 with wd_sel = 01. instr_cnt = 2.
- beq with zero = 0, then beq with zero = 1 -> 3 cycles each. pc_wr in S_BRANCH is 0 then 1, with npc_sel = 01.
- jal -> in S_JUMP: pc_wr = 1, npc_sel = 10, reg_wr = 1, reg_dst = 10, wd_sel = 10. jr -> npc_sel = 11, reg_wr = 0.
- sw with dm_rdy low for 3 cycles -> mem_wr held high for 4 cycles in S_MEM_WR, then S_FETCH. No reg_wr occurs.
- opcode 111111 -> illegal pulses for 1 cycle in S_DECODE, then S_FETCH with instr_cnt unchanged. Reset asserted in S_WB_MEM -> reg_wr drops to 0 immediately and state = S_FETCH.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS-lite definitions: opcode/funct constants, controller state encodings,
// datapath select codes and the packed control word produced by the decoder.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXE_R   = 4'd2,
    S_EXE_I   = 4'd3,
    S_WB_ALU  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MDR   = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic       illegal;
    logic       alu_src;
    logic [1:0] npc_sel;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Dispatch target out of S_DECODE; S_FETCH doubles as the "unsupported" marker.
  function automatic state_t decode_target(input logic [5:0] opcode, input logic [5:0] funct);
    state_t tgt;
    tgt = S_FETCH;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) tgt = S_EXE_R;
        else if (funct == FN_JR)                  tgt = S_JUMP;
      end
      OP_ORI, OP_LUI:     tgt = S_EXE_I;
      OP_LW, OP_SW:       tgt = S_MEM_ADR;
      OP_BEQ:             tgt = S_BRANCH;
      OP_J, OP_JAL:       tgt = S_JUMP;
      default:            tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational Moore decoder: current state plus IR fields to control word.
// Strobes leave here ungated; the top applies the reset gating.
module mc_ctrl_dec
  import mips_defs::*;
(
  input  logic [3:0]        state,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              im_rdy,
  output logic [CTRL_W-1:0] ctrl_word
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.ir_wr   = im_rdy;
        c.pc_wr   = im_rdy;
        c.npc_sel = NPC_PC4;
      end
      S_DECODE: begin
        c.illegal = (decode_target(opcode, funct) == S_FETCH);
      end
      S_EXE_R: begin
        c.alu_src = 1'b0;
        c.alu_op  = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end
      S_EXE_I: begin
        c.alu_src = 1'b1;
        c.ext_op  = (opcode == OP_LUI) ? EXT_LUI : EXT_ZERO;
        c.alu_op  = (opcode == OP_LUI) ? ALU_PASS : ALU_OR;
      end
      S_WB_ALU: begin
        c.reg_wr  = 1'b1;
        c.wd_sel  = WD_ALU;
        c.reg_dst = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
      end
      // Address controls stay up through the memory states so the DM sees a stable address.
      S_MEM_ADR, S_MEM_RD: begin
        c.alu_src = 1'b1;
        c.ext_op  = EXT_SIGN;
        c.alu_op  = ALU_ADD;
      end
      S_MEM_WR: begin
        c.alu_src = 1'b1;
        c.ext_op  = EXT_SIGN;
        c.alu_op  = ALU_ADD;
        c.mem_wr  = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_wr  = 1'b1;
        c.reg_dst = RD_RT;
        c.wd_sel  = WD_MDR;
      end
      S_BRANCH: begin
        c.alu_src = 1'b0;
        c.alu_op  = ALU_SUB;
        c.npc_sel = NPC_BR;
        c.pc_wr   = zero;
      end
      S_JUMP: begin
        c.pc_wr = 1'b1;
        if (opcode == OP_RTYPE) begin
          c.npc_sel = NPC_RS;
        end else begin
          c.npc_sel = NPC_J;
          if (opcode == OP_JAL) begin
            c.reg_wr  = 1'b1;
            c.reg_dst = RD_RA;
            c.wd_sel  = WD_PC;
          end
        end
      end
      default: c = '0;
    endcase
  end

  assign ctrl_word = c;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite main controller: state register, next-state logic and
// retired-instruction counter around the mc_ctrl_dec control-word decoder.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int         CNT_W     = 32,
  parameter logic [3:0] RST_STATE = 4'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             im_rdy,
  input  logic             dm_rdy,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_sel,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_wr,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [3:0]        state;
  logic [3:0]        next_state;
  logic              retire;
  logic [CTRL_W-1:0] ctrl_word;
  ctrl_t             ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RST_STATE;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Unused encodings fall through to the default and recover to S_FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = im_rdy ? S_DECODE : S_FETCH;
      S_DECODE:  next_state = decode_target(opcode, funct);
      S_EXE_R:   next_state = S_WB_ALU;
      S_EXE_I:   next_state = S_WB_ALU;
      S_MEM_ADR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  next_state = dm_rdy ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:  next_state = dm_rdy ? S_FETCH : S_MEM_WR;
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (next_state == S_FETCH) begin
      case (state)
        S_WB_ALU, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  mc_ctrl_dec u_dec (
    .state     (state),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .im_rdy    (im_rdy),
    .ctrl_word (ctrl_word)
  );

  assign ctrl = ctrl_t'(ctrl_word);

  // Strobes are masked by reset so an abort cannot leak a write on the asserting edge.
  assign pc_wr   = ctrl.pc_wr   & ~reset;
  assign ir_wr   = ctrl.ir_wr   & ~reset;
  assign reg_wr  = ctrl.reg_wr  & ~reset;
  assign mem_wr  = ctrl.mem_wr  & ~reset;
  assign illegal = ctrl.illegal & ~reset;
  assign npc_sel = ctrl.npc_sel;
  assign reg_dst = ctrl.reg_dst;
  assign wd_sel  = ctrl.wd_sel;
  assign alu_src = ctrl.alu_src;
  assign alu_op  = ctrl.alu_op;
  assign ext_op  = ctrl.ext_op;
  assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class through
// its state sequence with hand-computed control values.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        im_rdy;
  logic        dm_rdy;
  logic        pc_wr;
  logic        ir_wr;
  logic [1:0]  npc_sel;
  logic        reg_wr;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [1:0]  ext_op;
  logic        mem_wr;
  logic        illegal;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .im_rdy    (im_rdy),
    .dm_rdy    (dm_rdy),
    .pc_wr     (pc_wr),
    .ir_wr     (ir_wr),
    .npc_sel   (npc_sel),
    .reg_wr    (reg_wr),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .ext_op    (ext_op),
    .mem_wr    (mem_wr),
    .illegal   (illegal),
    .state_o   (state_o),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    im_rdy = 1'b1;
    dm_rdy = 1'b1;
    zero   = 1'b0;
    applyStimulus(6'b000000, 6'b000000);

    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("rst_state", state_o, 32'd0);
      checkOutput("rst_strobes", {pc_wr, ir_wr, reg_wr, mem_wr, illegal}, 32'd0);
      checkOutput("rst_cnt", instr_cnt, 32'd0);
    end

    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("fetch_ir_wr", ir_wr, 32'd1);
    checkOutput("fetch_pc_wr", pc_wr, 32'd1);
    checkOutput("fetch_npc", npc_sel, 32'd0);

    // addu: FETCH DECODE EXE_R WB_ALU
    applyStimulus(6'b000000, 6'b100001);
    stepCycle();
    checkOutput("addu_dec_state", state_o, 32'd1);
    checkOutput("addu_dec_strobes", {pc_wr, ir_wr, reg_wr, mem_wr, illegal}, 32'd0);
    stepCycle();
    checkOutput("addu_exe_state", state_o, 32'd2);
    checkOutput("addu_exe_ctl", {alu_src, alu_op}, {28'd0, 1'b0, 3'b000});
    stepCycle();
    checkOutput("addu_wb_state", state_o, 32'd4);
    checkOutput("addu_wb_ctl", {reg_wr, reg_dst, wd_sel}, {27'd0, 1'b1, 2'b01, 2'b00});
    stepCycle();
    checkOutput("addu_done_state", state_o, 32'd0);
    checkOutput("addu_cnt", instr_cnt, 32'd1);

    // lw: FETCH DECODE MEM_ADR MEM_RD WB_MEM
    applyStimulus(6'b100011, 6'b000000);
    stepCycle();
    stepCycle();
    checkOutput("lw_adr_state", state_o, 32'd5);
    checkOutput("lw_adr_ctl", {alu_src, ext_op, alu_op}, {26'd0, 1'b1, 2'b01, 3'b000});
    stepCycle();
    checkOutput("lw_rd_state", state_o, 32'd6);
    stepCycle();
    checkOutput("lw_wb_state", state_o, 32'd8);
    checkOutput("lw_wb_ctl", {reg_wr, reg_dst, wd_sel}, {27'd0, 1'b1, 2'b00, 2'b01});
    stepCycle();
    checkOutput("lw_cnt", instr_cnt, 32'd2);

    // beq not taken, then taken
    applyStimulus(6'b000100, 6'b000000);
    zero = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("beq0_state", state_o, 32'd9);
    checkOutput("beq0_ctl", {pc_wr, npc_sel, alu_op}, {26'd0, 1'b0, 2'b01, 3'b001});
    stepCycle();
    checkOutput("beq0_cnt", instr_cnt, 32'd3);
    zero = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("beq1_ctl", {pc_wr, npc_sel}, {29'd0, 1'b1, 2'b01});
    stepCycle();
    checkOutput("beq1_state", state_o, 32'd0);
    zero = 1'b0;

    // jal, then jr
    applyStimulus(6'b000011, 6'b000000);
    stepCycle();
    stepCycle();
    checkOutput("jal_state", state_o, 32'd10);
    checkOutput("jal_ctl", {pc_wr, npc_sel, reg_wr, reg_dst, wd_sel},
                {24'd0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10});
    stepCycle();
    applyStimulus(6'b000000, 6'b001000);
    stepCycle();
    stepCycle();
    checkOutput("jr_ctl", {pc_wr, npc_sel, reg_wr}, {28'd0, 1'b1, 2'b11, 1'b0});
    stepCycle();
    checkOutput("jr_cnt", instr_cnt, 32'd6);

    // sw with dm_rdy low for three cycles in S_MEM_WR
    applyStimulus(6'b101011, 6'b000000);
    dm_rdy = 1'b0;
    stepCycle();
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("sw_wait_state", state_o, 32'd7);
      checkOutput("sw_wait_ctl", {mem_wr, reg_wr}, 32'd2);
    end
    dm_rdy = 1'b1;
    #1;
    checkOutput("sw_last_ctl", {mem_wr, reg_wr}, 32'd2);
    stepCycle();
    checkOutput("sw_done_state", state_o, 32'd0);
    checkOutput("sw_cnt", instr_cnt, 32'd7);

    // unsupported opcode
    applyStimulus(6'b111111, 6'b000000);
    stepCycle();
    checkOutput("ill_pulse", illegal, 32'd1);
    stepCycle();
    checkOutput("ill_state", state_o, 32'd0);
    checkOutput("ill_gone", illegal, 32'd0);
    checkOutput("ill_cnt", instr_cnt, 32'd7);

    // reset mid-instruction in S_WB_MEM
    applyStimulus(6'b100011, 6'b000000);
    stepCycle();
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("abort_pre_wr", reg_wr, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_reg_wr", reg_wr, 32'd0);
    checkOutput("abort_state", state_o, 32'd0);
    checkOutput("abort_cnt", instr_cnt, 32'd0);
    stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("abort_refetch", {ir_wr, pc_wr}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
